// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation modes and the datapath mux-select / ALU-control codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // The extender format follows the opcode alone, whatever the FSM state.
    function automatic logic [1:0] immsrc_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU mode plus instruction funct fields onto the ALU control code.
module alu_decoder
    import multicycle_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-type, so addi never becomes sub
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle datapath, one resource use per cycle.
// o_state exposes the current state for debug and checkers.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic [1:0] o_immsrc,
    output logic [1:0] o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_resultsrc,
    output logic       o_adrsrc,
    output logic       o_irwrite,
    output logic       o_pcwrite,
    output logic       o_regwrite,
    output logic       o_memwrite,
    output logic [2:0] o_alucontrol,
    output logic       o_illegal,
    output state_t     o_state
);

    state_t state, state_next;
    aluop_t aluop;
    logic   irwrite, pcwrite, regwrite, memwrite;
    logic   taken;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        case (i_funct3)
            3'b000:  taken = i_zero;
            3'b001:  taken = !i_zero;
            default: taken = 1'b0;
        endcase
    end

    // Memory handshake: an access in FETCH, MEMREAD or MEMWRITE completes in the
    // cycle i_mem_ready is 1; until then the state holds and its selects stay put.
    always_comb begin
        state_next  = state;
        aluop       = ALUOP_ADD;
        o_alusrca   = SRCA_PC;
        o_alusrcb   = SRCB_RS2;
        o_resultsrc = RES_ALUOUT;
        o_adrsrc    = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        regwrite    = 1'b0;
        memwrite    = 1'b0;
        o_illegal   = 1'b0;
        case (state)
            FETCH: begin
                o_alusrcb   = SRCB_4;
                o_resultsrc = RES_ALU;
                irwrite     = i_mem_ready;
                pcwrite     = i_mem_ready;
                if (i_mem_ready) state_next = DECODE;
            end
            DECODE: begin
                o_alusrca = SRCA_OLDPC;
                o_alusrcb = SRCB_IMM;
                case (i_op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_BR:        state_next = BRANCH;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR: begin
                o_alusrca  = SRCA_RS1;
                o_alusrcb  = SRCB_IMM;
                state_next = (i_op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                o_adrsrc = 1'b1;
                if (i_mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                o_resultsrc = RES_DATA;
                regwrite    = 1'b1;
                state_next  = FETCH;
            end
            MEMWRITE: begin
                o_adrsrc = 1'b1;
                memwrite = 1'b1;
                if (i_mem_ready) state_next = FETCH;
            end
            EXECUTER: begin
                o_alusrca  = SRCA_RS1;
                aluop      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                o_alusrca  = SRCA_RS1;
                o_alusrcb  = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                o_alusrca  = SRCA_RS1;
                aluop      = ALUOP_SUB;
                pcwrite    = taken;
                state_next = FETCH;
            end
            JAL: begin
                o_alusrca  = SRCA_OLDPC;
                o_alusrcb  = SRCB_4;
                pcwrite    = 1'b1;
                state_next = ALUWB;
            end
            TRAP: o_illegal = 1'b1;
            default: state_next = FETCH;
        endcase
    end

    // Strobes are masked during reset so an aborted instruction writes nothing.
    assign o_irwrite  = irwrite  & ~i_rst;
    assign o_pcwrite  = pcwrite  & ~i_rst;
    assign o_regwrite = regwrite & ~i_rst;
    assign o_memwrite = memwrite & ~i_rst;
    assign o_immsrc   = immsrc_of(i_op);
    assign o_state    = state;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (i_funct3),
        .op5        (i_op[5]),
        .funct7b5   (i_funct7b5),
        .alucontrol (o_alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each driven cycle pushes its hand-derived
// control vector; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_controller;
    import multicycle_pkg::*;

    localparam int W = 21;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [6:0] i_op = 7'b0110011;
    logic [2:0] i_funct3 = 3'b000;
    logic       i_funct7b5 = 1'b0;
    logic       i_zero = 1'b0;
    logic       i_mem_ready = 1'b1;
    logic [1:0] o_immsrc, o_alusrca, o_alusrcb, o_resultsrc;
    logic       o_adrsrc, o_irwrite, o_pcwrite, o_regwrite, o_memwrite, o_illegal;
    logic [2:0] o_alucontrol;
    state_t     o_state;

    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_op         (i_op),
        .i_funct3     (i_funct3),
        .i_funct7b5   (i_funct7b5),
        .i_zero       (i_zero),
        .i_mem_ready  (i_mem_ready),
        .o_immsrc     (o_immsrc),
        .o_alusrca    (o_alusrca),
        .o_alusrcb    (o_alusrcb),
        .o_resultsrc  (o_resultsrc),
        .o_adrsrc     (o_adrsrc),
        .o_irwrite    (o_irwrite),
        .o_pcwrite    (o_pcwrite),
        .o_regwrite   (o_regwrite),
        .o_memwrite   (o_memwrite),
        .o_alucontrol (o_alucontrol),
        .o_illegal    (o_illegal),
        .o_state      (o_state)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    // vector layout: state, immsrc, alusrca, alusrcb, resultsrc, adrsrc,
    // irwrite, pcwrite, regwrite, memwrite, alucontrol, illegal
    function automatic logic [W-1:0] v(input logic [3:0] st, input logic [1:0] imm,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic adr,
                                       input logic ir, input logic pc, input logic rw,
                                       input logic mw, input logic [2:0] alu,
                                       input logic ill);
        return {st, imm, a, b, rs, adr, ir, pc, rw, mw, alu, ill};
    endfunction

    function automatic logic [W-1:0] e_fetch(input logic [1:0] imm, input logic rdy);
        return v(4'd0, imm, 2'b00, 2'b10, 2'b10, 1'b0, rdy, rdy, 1'b0, 1'b0, 3'b000, 1'b0);
    endfunction

    function automatic logic [W-1:0] e_decode(input logic [1:0] imm);
        return v(4'd1, imm, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endfunction

    // driver: apply one cycle of inputs together with the expected outputs
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input logic rdy, input logic rst,
                        input logic [W-1:0] e);
        i_op = op; i_funct3 = f3; i_funct7b5 = f7;
        i_zero = z; i_mem_ready = rdy; i_rst = rst;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge i_clk) begin
        logic [W-1:0] act, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {o_state, o_immsrc, o_alusrca, o_alusrcb, o_resultsrc, o_adrsrc,
                   o_irwrite, o_pcwrite, o_regwrite, o_memwrite, o_alucontrol, o_illegal};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctl_vec t=%0t got=%b want=%b", $time, act, e);
            end
        end
    end

    initial begin
        @(posedge i_clk);
        #1;
        // reset held: state already FETCH, strobes masked
        step(OP_R, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, e_fetch(2'b00, 1'b0));

        // R-type sub
        step(OP_R, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, e_fetch(2'b00, 1'b1));
        step(OP_R, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, e_decode(2'b00));
        step(OP_R, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0,
             v(4'd6, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b001, 0));
        step(OP_R, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0,
             v(4'd8, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 0));

        // R-type slt
        step(OP_R, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_fetch(2'b00, 1'b1));
        step(OP_R, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(2'b00));
        step(OP_R, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd6, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b101, 0));
        step(OP_R, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd8, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 0));

        // I-type ori; funct7b5 set but op[5]=0, and addi-style sub must not appear
        step(OP_I, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, e_fetch(2'b00, 1'b1));
        step(OP_I, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, e_decode(2'b00));
        step(OP_I, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0,
             v(4'd7, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b011, 0));
        step(OP_I, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0,
             v(4'd8, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 0));

        // I-type addi with funct7b5=1 stays add
        step(OP_I, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, e_fetch(2'b00, 1'b1));
        step(OP_I, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, e_decode(2'b00));
        step(OP_I, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0,
             v(4'd7, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
        step(OP_I, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0,
             v(4'd8, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 0));

        // lw with two wait cycles in MEMREAD
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_fetch(2'b00, 1'b1));
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(2'b00));
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd2, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
             v(4'd3, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0));
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
             v(4'd3, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0));
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd3, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0));
        step(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd4, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 3'b000, 0));

        // sw zero-wait
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_fetch(2'b01, 1'b1));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(2'b01));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd2, 2'b01, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd5, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 3'b000, 0));

        // sw with a fetch stall and a write stall
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(2'b01, 1'b0));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_fetch(2'b01, 1'b1));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(2'b01));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd2, 2'b01, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
             v(4'd5, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 3'b000, 0));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd5, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 3'b000, 0));

        // branches: beq z=1 taken, beq z=0 not, bne z=0 taken, blt never
        for (int k = 0; k < 4; k++) begin
            logic [2:0] f3;
            logic       z, tk;
            case (k)
                0:       begin f3 = 3'b000; z = 1'b1; tk = 1'b1; end
                1:       begin f3 = 3'b000; z = 1'b0; tk = 1'b0; end
                2:       begin f3 = 3'b001; z = 1'b0; tk = 1'b1; end
                default: begin f3 = 3'b100; z = 1'b1; tk = 1'b0; end
            endcase
            step(OP_BR, f3, 1'b0, z, 1'b1, 1'b0, e_fetch(2'b10, 1'b1));
            step(OP_BR, f3, 1'b0, z, 1'b1, 1'b0, e_decode(2'b10));
            step(OP_BR, f3, 1'b0, z, 1'b1, 1'b0,
                 v(4'd9, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, tk, 0, 0, 3'b001, 0));
        end

        // jal
        step(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, e_fetch(2'b11, 1'b1));
        step(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(2'b11));
        step(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd10, 2'b11, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 3'b000, 0));
        step(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd8, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 0));

        // illegal opcode traps and holds, reset recovers
        step(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, e_fetch(2'b00, 1'b1));
        step(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(2'b00));
        for (int k = 0; k < 3; k++)
            step(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0,
                 v(4'd11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));
        step(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1,
             v(4'd11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_fetch(2'b01, 1'b1));

        // reset asserted in MEMWRITE: strobe masked, then FETCH
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(2'b01));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0,
             v(4'd2, 2'b01, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1,
             v(4'd5, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0));
        step(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, e_fetch(2'b01, 1'b1));

        @(negedge i_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0 pending vectors", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
